reservation_station: RTL and testbench

Receiving end of the issue stage for ALU and branch instructions. It holds up to RS_SIZE decoded instructions and their V/Q operand pairs, and snoops the common data bus (CDB) to resolve pending tags. Each cycle it dispatches the lowest-index entry whose operands are both resolved to the ALU. It reports full back to issue; the ROB can flush it on mispredict.

---
 rtl/reservation_station.sv | 184 ++++++++++++++++++
 tb/tb_reservation_station.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : reservation_station
// Purpose  : Issue-side reservation station for ALU and branch instructions.
//            Holds up to RS_SIZE decoded instructions with V/Q operand pairs,
//            snoops the CDB to resolve pending producer tags, and dispatches
//            the lowest-index fully-ready entry to the ALU each cycle.
// Ports    : clk_in / rst_in (async, active-low) / rdy_in (global stall)
//            clear_in            - mispredict flush from ROB
//            has_instr + fields  - instruction presented by issue
//            full                - all entries busy (combinational)
//            cdb_*               - common data bus broadcast
//            alu_*               - registered dispatch to the ALU
// Revision : 1.0 - initial release
// ============================================================================
module reservation_station #(
  parameter int RS_SIZE = 8,
  parameter int Q_WIDTH = 5
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear_in,
  input  logic               has_instr,
  input  logic [6:0]         opcode,
  input  logic [2:0]         func3,
  input  logic [6:0]         func7,
  input  logic [31:0]        V1,
  input  logic [31:0]        V2,
  input  logic [Q_WIDTH-1:0] Q1,
  input  logic [Q_WIDTH-1:0] Q2,
  input  logic [31:0]        immediate,
  input  logic [31:0]        npc,
  input  logic [Q_WIDTH-1:0] dest,
  output logic               full,
  input  logic               cdb_valid,
  input  logic [Q_WIDTH-1:0] cdb_tag,
  input  logic [31:0]        cdb_value,
  output logic               alu_valid,
  output logic [6:0]         alu_opcode,
  output logic [2:0]         alu_func3,
  output logic [6:0]         alu_func7,
  output logic [31:0]        alu_V1,
  output logic [31:0]        alu_V2,
  output logic [31:0]        alu_imm,
  output logic [31:0]        alu_pc,
  output logic [Q_WIDTH-1:0] alu_dest
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  // Entry storage
  logic [RS_SIZE-1:0] r_busy;
  logic [6:0]         r_opcode [RS_SIZE];
  logic [2:0]         r_func3  [RS_SIZE];
  logic [6:0]         r_func7  [RS_SIZE];
  logic [31:0]        r_v1     [RS_SIZE];
  logic [31:0]        r_v2     [RS_SIZE];
  logic [Q_WIDTH-1:0] r_q1     [RS_SIZE];
  logic [Q_WIDTH-1:0] r_q2     [RS_SIZE];
  logic [31:0]        r_imm    [RS_SIZE];
  logic [31:0]        r_pc     [RS_SIZE];
  logic [Q_WIDTH-1:0] r_dest   [RS_SIZE];

  logic [RS_SIZE-1:0] w_ready;
  logic               w_sel_valid;
  logic [IDX_W-1:0]   w_sel_idx;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_issue;
  logic               w_cdb_hit;
  logic               w_byp1;
  logic               w_byp2;

  // A slot freed by this cycle's dispatch is still counted busy here.
  assign full = &r_busy;

  generate
    for (genvar g = 0; g < RS_SIZE; g++) begin : g_ready
      assign w_ready[g] = r_busy[g] && (r_q1[g] == '0) && (r_q2[g] == '0);
    end
  endgenerate

  // Priority encoders: scan high-to-low so the lowest index wins.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    w_free_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = IDX_W'(i);
      end
      if (!r_busy[i]) begin
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign w_issue   = has_instr && !full;
  // Tag 0 means "no dependency" and must never wake anything.
  assign w_cdb_hit = cdb_valid && (cdb_tag != '0);
  assign w_byp1    = w_cdb_hit && (cdb_tag == Q1);
  assign w_byp2    = w_cdb_hit && (cdb_tag == Q2);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_busy     <= '0;
      alu_valid  <= 1'b0;
      alu_opcode <= '0;
      alu_func3  <= '0;
      alu_func7  <= '0;
      alu_V1     <= '0;
      alu_V2     <= '0;
      alu_imm    <= '0;
      alu_pc     <= '0;
      alu_dest   <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_opcode[i] <= '0;
        r_func3[i]  <= '0;
        r_func7[i]  <= '0;
        r_v1[i]     <= '0;
        r_v2[i]     <= '0;
        r_q1[i]     <= '0;
        r_q2[i]     <= '0;
        r_imm[i]    <= '0;
        r_pc[i]     <= '0;
        r_dest[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (clear_in) begin
        r_busy    <= '0;
        alu_valid <= 1'b0;
      end else begin
        // CDB snoop on resident entries
        for (int i = 0; i < RS_SIZE; i++) begin
          if (w_cdb_hit && r_busy[i]) begin
            if (r_q1[i] == cdb_tag) begin
              r_v1[i] <= cdb_value;
              r_q1[i] <= '0;
            end
            if (r_q2[i] == cdb_tag) begin
              r_v2[i] <= cdb_value;
              r_q2[i] <= '0;
            end
          end
        end

        // Dispatch uses operand state from the start of the cycle
        if (w_sel_valid) begin
          alu_valid           <= 1'b1;
          alu_opcode          <= r_opcode[w_sel_idx];
          alu_func3           <= r_func3[w_sel_idx];
          alu_func7           <= r_func7[w_sel_idx];
          alu_V1              <= r_v1[w_sel_idx];
          alu_V2              <= r_v2[w_sel_idx];
          alu_imm             <= r_imm[w_sel_idx];
          alu_pc              <= r_pc[w_sel_idx];
          alu_dest            <= r_dest[w_sel_idx];
          r_busy[w_sel_idx]   <= 1'b0;
        end else begin
          alu_valid <= 1'b0;
        end

        // Issue targets a slot free at cycle start, so it never collides
        // with the dispatched slot or with the snoop above.
        if (w_issue) begin
          r_busy[w_free_idx]   <= 1'b1;
          r_opcode[w_free_idx] <= opcode;
          r_func3[w_free_idx]  <= func3;
          r_func7[w_free_idx]  <= func7;
          r_imm[w_free_idx]    <= immediate;
          r_pc[w_free_idx]     <= npc;
          r_dest[w_free_idx]   <= dest;
          r_v1[w_free_idx]     <= w_byp1 ? cdb_value : V1;
          r_q1[w_free_idx]     <= w_byp1 ? '0 : Q1;
          r_v2[w_free_idx]     <= w_byp2 ? cdb_value : V2;
          r_q2[w_free_idx]     <= w_byp2 ? '0 : Q2;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : tb_reservation_station
// Purpose  : Self-checking bench for reservation_station. Directed scenarios
//            followed by random traffic, all compared every cycle against a
//            behavioural entry-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reservation_station;

  localparam int RS = 8;
  localparam int QW = 5;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          rdy_in = 1'b0;
  logic          clear_in = 1'b0;
  logic          has_instr = 1'b0;
  logic [6:0]    opcode = '0;
  logic [2:0]    func3 = '0;
  logic [6:0]    func7 = '0;
  logic [31:0]   V1 = '0, V2 = '0, immediate = '0, npc = '0;
  logic [QW-1:0] Q1 = '0, Q2 = '0, dest = '0;
  logic          cdb_valid = 1'b0;
  logic [QW-1:0] cdb_tag = '0;
  logic [31:0]   cdb_value = '0;

  logic          full, alu_valid;
  logic [6:0]    alu_opcode, alu_func7;
  logic [2:0]    alu_func3;
  logic [31:0]   alu_V1, alu_V2, alu_imm, alu_pc;
  logic [QW-1:0] alu_dest;

  reservation_station #(.RS_SIZE(RS), .Q_WIDTH(QW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .has_instr(has_instr), .opcode(opcode), .func3(func3), .func7(func7),
    .V1(V1), .V2(V2), .Q1(Q1), .Q2(Q2), .immediate(immediate), .npc(npc),
    .dest(dest), .full(full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .alu_valid(alu_valid), .alu_opcode(alu_opcode),
    .alu_func3(alu_func3), .alu_func7(alu_func7), .alu_V1(alu_V1),
    .alu_V2(alu_V2), .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_dest(alu_dest)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- reference model ----------------
  typedef struct {
    bit            busy;
    logic [6:0]    op;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic [31:0]   v1, v2, imm, pc;
    logic [QW-1:0] q1, q2, dst;
  } ent_t;

  ent_t         m [RS];
  logic         m_valid;
  logic [149:0] m_pay;

  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [149:0] pay_of(ent_t e);
    return {e.op, e.f3, e.f7, e.v1, e.v2, e.imm, e.pc, e.dst};
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < RS; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
    m_valid = 1'b0;
    m_pay   = '0;
  endtask

  // Effect of one rising edge given the inputs currently applied.
  task automatic model_edge();
    int   sel;
    int   fr;
    ent_t e;
    if (!rdy_in) return;
    if (clear_in) begin
      for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
      m_valid = 1'b0;
      return;
    end
    sel = -1;
    fr  = -1;
    for (int i = 0; i < RS; i++) begin
      if (sel < 0 && m[i].busy && m[i].q1 == 0 && m[i].q2 == 0) sel = i;
      if (fr < 0 && !m[i].busy) fr = i;
    end
    if (sel >= 0) begin
      m_valid      = 1'b1;
      m_pay        = pay_of(m[sel]);
      m[sel].busy  = 1'b0;
    end else begin
      m_valid = 1'b0;
    end
    if (cdb_valid && cdb_tag != 0) begin
      for (int i = 0; i < RS; i++) begin
        if (m[i].busy && m[i].q1 == cdb_tag) begin m[i].v1 = cdb_value; m[i].q1 = 0; end
        if (m[i].busy && m[i].q2 == cdb_tag) begin m[i].v2 = cdb_value; m[i].q2 = 0; end
      end
    end
    if (has_instr && fr >= 0) begin
      e.busy = 1'b1; e.op = opcode; e.f3 = func3; e.f7 = func7;
      e.imm = immediate; e.pc = npc; e.dst = dest;
      e.v1 = V1; e.q1 = Q1; e.v2 = V2; e.q2 = Q2;
      if (cdb_valid && Q1 != 0 && cdb_tag == Q1) begin e.v1 = cdb_value; e.q1 = 0; end
      if (cdb_valid && Q2 != 0 && cdb_tag == Q2) begin e.v2 = cdb_value; e.q2 = 0; end
      m[fr] = e;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(string tag, logic [159:0] obs, logic [159:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("alu_valid", 160'(alu_valid), 160'(m_valid));
    chk("alu_payload", 160'({alu_opcode, alu_func3, alu_func7, alu_V1, alu_V2,
                             alu_imm, alu_pc, alu_dest}), 160'(m_pay));
    chk("full", 160'(full), 160'(m_full()));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_in);
    #1;
    check_outputs();
  endtask

  task automatic drive(bit hi, logic [6:0] op, logic [31:0] v1, logic [QW-1:0] q1,
                       logic [31:0] v2, logic [QW-1:0] q2, logic [QW-1:0] d);
    has_instr = hi; opcode = op;
    V1 = v1; Q1 = q1; V2 = v2; Q2 = q2; dest = d;
    func3 = 3'($urandom); func7 = 7'($urandom);
    immediate = $urandom; npc = $urandom;
  endtask

  task automatic cdb(bit v, logic [QW-1:0] t, logic [31:0] val);
    cdb_valid = v; cdb_tag = t; cdb_value = val;
  endtask

  task automatic idle();
    has_instr = 1'b0; cdb_valid = 1'b0; clear_in = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #12;
    chk("reset_alu_valid", 160'(alu_valid), 160'(0));
    chk("reset_full", 160'(full), 160'(0));
    check_outputs();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Ready-operand issue
    drive(1, 7'h33, 32'd5, 0, 32'd7, 0, 5'd3);
    step();
    idle();
    step();
    chk("ready_valid", 160'(alu_valid), 160'(1));
    chk("ready_V1", 160'(alu_V1), 160'(5));
    chk("ready_V2", 160'(alu_V2), 160'(7));
    chk("ready_dest", 160'(alu_dest), 160'(3));
    step();
    chk("ready_valid_drop", 160'(alu_valid), 160'(0));

    // Wakeup through CDB snoop
    drive(1, 7'h13, 32'hdead, 5'd4, 32'd9, 0, 5'd5);
    step();
    idle();
    step();
    cdb(1, 5'd4, 32'h100);
    step();
    chk("wake_not_yet", 160'(alu_valid), 160'(0));
    idle();
    step();
    chk("wake_valid", 160'(alu_valid), 160'(1));
    chk("wake_V1", 160'(alu_V1), 160'(32'h100));
    chk("wake_V2", 160'(alu_V2), 160'(9));

    // Issue-time bypass
    drive(1, 7'h33, 32'hbeef, 5'd4, 32'd1, 0, 5'd6);
    cdb(1, 5'd4, 32'h200);
    step();
    idle();
    step();
    chk("bypass_valid", 160'(alu_valid), 160'(1));
    chk("bypass_V1", 160'(alu_V1), 160'(32'h200));
    step();

    // Fill all entries waiting on tag 6
    for (int i = 0; i < RS; i++) begin
      drive(1, 7'h33, 32'(i), 5'd6, 32'(i + 100), 0, 5'(i + 1));
      step();
    end
    idle();
    chk("full_set", 160'(full), 160'(1));
    cdb(1, 5'd6, 32'h600);
    step();
    idle();
    chk("full_held", 160'(full), 160'(1));
    for (int i = 0; i < RS; i++) begin
      step();
      chk("full_order_dest", 160'(alu_dest), 160'(i + 1));
      chk("full_order_V2", 160'(alu_V2), 160'(i + 100));
    end
    chk("full_after_drain", 160'(full), 160'(0));
    step();
    chk("drain_idle", 160'(alu_valid), 160'(0));

    // Flush with competing issue and broadcast
    for (int i = 0; i < 4; i++) begin
      drive(1, 7'h63, 32'(i), 5'd7, 32'd0, 0, 5'(i + 10));
      step();
    end
    drive(1, 7'h33, 32'd1, 0, 32'd2, 0, 5'd20);
    cdb(1, 5'd7, 32'h700);
    clear_in = 1'b1;
    step();
    chk("flush_valid", 160'(alu_valid), 160'(0));
    idle();
    cdb(1, 5'd7, 32'h701);
    step();
    idle();
    step();
    chk("flush_gone", 160'(alu_valid), 160'(0));
    chk("flush_full", 160'(full), 160'(0));

    // Freeze mid-sequence
    for (int i = 0; i < 3; i++) begin
      drive(1, 7'h33, 32'(i), 5'd8, 32'd0, 0, 5'(i + 21));
      step();
    end
    idle();
    cdb(1, 5'd8, 32'h800);
    step();
    idle();
    step();
    chk("freeze_first", 160'(alu_dest), 160'(21));
    rdy_in = 1'b0;
    drive(1, 7'h33, 32'd3, 0, 32'd4, 0, 5'd30);
    cdb(1, 5'd8, 32'h801);
    for (int i = 0; i < 3; i++) step();
    chk("freeze_hold_valid", 160'(alu_valid), 160'(1));
    chk("freeze_hold_dest", 160'(alu_dest), 160'(21));
    rdy_in = 1'b1;
    idle();
    step();
    chk("resume_second", 160'(alu_dest), 160'(22));
    step();
    chk("resume_third", 160'(alu_dest), 160'(23));
    step();

    // Asynchronous reset mid-operation
    drive(1, 7'h33, 32'habc, 0, 32'd1, 0, 5'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 7'h33, 32'(i), 5'd9, 32'd0, 0, 5'(i + 2));
      step();
    end
    idle();
    chk("pre_reset_V1", 160'(alu_V1), 160'(32'habc));
    #2 rst_in = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 160'(alu_valid), 160'(0));
    chk("arst_V1", 160'(alu_V1), 160'(0));
    chk("arst_full", 160'(full), 160'(0));
    check_outputs();
    #1 rst_in = 1'b1;

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      rdy_in   = ($urandom_range(0, 9) != 0);
      clear_in = ($urandom_range(0, 39) == 0);
      drive(($urandom_range(0, 9) < 6) && (!m_full() || $urandom_range(0, 7) == 0),
            7'($urandom), $urandom, 5'($urandom_range(0, 3)),
            $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(1, 31)));
      cdb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom);
      step();
    end
    idle();
    rdy_in = 1'b1;
    for (int c = 0; c < RS + 2; c++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
